// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - data-side memory stage adapter onto a single-outstanding req/ack bus
module mem_access_unit #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        memwrite,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic [1:0]        lo_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic              bus_err_q;
    logic [31:0]       bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic [3:0]        bus_wstrb_q;
    logic [31:0]       readdata_q;

    logic              is_byte;
    logic              is_half;
    logic              misaligned;
    logic [3:0]        wstrb_d;
    logic [31:0]       wdata_d;
    logic [31:0]       rdata_ext_d;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;

    // Size decode, alignment check and the combinational core handshake
    always_comb begin
        is_byte    = (mem_op[1:0] == 2'b00);
        is_half    = (mem_op[1:0] == 2'b01);
        // Reserved size 11 behaves as a word, including for alignment
        misaligned = (is_half & addr[0]) | (!is_byte & !is_half & (addr[1:0] != 2'b00));
        stall      = !rst & mem_en & !misaligned & (state_q != S_DONE);
        adel       = !rst & mem_en & misaligned & !memwrite & (state_q == S_IDLE);
        ades       = !rst & mem_en & misaligned & memwrite  & (state_q == S_IDLE);
    end

    // Store lane steering: replicate data across lanes, strobes pick the live bytes
    always_comb begin
        wstrb_d = 4'b1111;
        wdata_d = writedata;
        if (is_byte) begin
            wstrb_d = 4'b0001 << addr[1:0];
            wdata_d = {4{writedata[7:0]}};
        end else if (is_half) begin
            wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{writedata[15:0]}};
        end
    end

    // Load lane extraction and sign/zero extension from the latched request shape
    always_comb begin
        rdata_ext_d = bus_rdata;
        case (lo_q)
            2'd0:    rbyte = bus_rdata[7:0];
            2'd1:    rbyte = bus_rdata[15:8];
            2'd2:    rbyte = bus_rdata[23:16];
            default: rbyte = bus_rdata[31:24];
        endcase
        rhalf = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        if (size_q == 2'b00) begin
            rdata_ext_d = zext_q ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
        end else if (size_q == 2'b01) begin
            rdata_ext_d = zext_q ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
        end
    end

    // Access sequencer: IDLE latches the request, WAIT holds the bus until ack or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            zext_q      <= 1'b0;
            lo_q        <= 2'b00;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'h0;
            readdata_q  <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    bus_err_q <= 1'b0;
                    if (mem_en && !misaligned) begin
                        bus_addr_q  <= {addr[31:2], 2'b00};
                        bus_we_q    <= memwrite;
                        bus_wstrb_q <= memwrite ? wstrb_d : 4'b0000;
                        bus_wdata_q <= wdata_d;
                        size_q      <= mem_op[1:0];
                        zext_q      <= mem_op[2];
                        lo_q        <= addr[1:0];
                        bus_req_q   <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ack wins over a timeout landing in the same cycle
                    if (bus_ack) begin
                        bus_req_q  <= 1'b0;
                        readdata_q <= bus_we_q ? 32'h0 : rdata_ext_d;
                        state_q    <= S_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        bus_req_q  <= 1'b0;
                        readdata_q <= 32'h0;
                        bus_err_q  <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    bus_err_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign readdata  = readdata_q;
    assign bus_err   = bus_err_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wstrb = bus_wstrb_q;
    assign bus_wdata = bus_wdata_q;

endmodule
